// File: rtl/button_conditioner.sv
// Per-channel button conditioner: synchroniser, bounce-suppressing hold-off FSM and press pulse.
// Optional feature: define AUTO_REPEAT_EN for periodic press pulses while a button stays held.
module button_conditioner #(
  parameter int N_CH        = 2,
  parameter int CR          = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RPT_CYC     = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            en_i,
  input  logic [N_CH-1:0] btn_i,
  output logic [N_CH-1:0] press_o,
  output logic [N_CH-1:0] level_o,
  output logic            valid_o
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    HELD = 2'd2
  } state_t;

  localparam logic [CR-1:0] CNT_LAST = {CR{1'b1}};
  localparam logic [CR-1:0] CNT_ONE  = CR'(1);
`ifdef AUTO_REPEAT_EN
  localparam logic [7:0] RPT_LAST = 8'(RPT_CYC - 1);
`endif

  if (N_CH < 1 || N_CH > 8) begin : g_bad_n_ch
    $error("button_conditioner: N_CH must be 1..8");
  end
  if (SYNC_STAGES < 2 || SYNC_STAGES > 3) begin : g_bad_sync
    $error("button_conditioner: SYNC_STAGES must be 2..3");
  end
  if (RPT_CYC < 2 || RPT_CYC > 255) begin : g_bad_rpt
    $error("button_conditioner: RPT_CYC must be 2..255");
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_o <= 1'b0;
    end else begin
      valid_o <= en_i;
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    state_t                 state_q;
    logic [CR-1:0]          cnt_q;
    logic                   press_q;
    logic                   level_q;
`ifdef AUTO_REPEAT_EN
    logic [7:0]             rpt_q;
`endif

    assign sync       = sync_q[SYNC_STAGES-1];
    assign press_o[g] = press_q;
    assign level_o[g] = level_q;

    // Synchroniser runs every cycle so the FSM sees a settled level the moment en_i returns.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        sync_q <= '0;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i[g]};
      end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        state_q <= IDLE;
        cnt_q   <= '0;
        press_q <= 1'b0;
        level_q <= 1'b0;
`ifdef AUTO_REPEAT_EN
        rpt_q   <= '0;
`endif
      end else if (!en_i) begin
        press_q <= 1'b0;
      end else begin
        press_q <= 1'b0;
        case (state_q)
          IDLE: begin
            if (sync) begin
              press_q <= 1'b1;
              level_q <= 1'b1;
              state_q <= LOCK;
              cnt_q   <= CNT_ONE;
            end
          end
          // Input is ignored here until the hold-off expires; only the final sample decides.
          LOCK: begin
            if (cnt_q == CNT_LAST) begin
              cnt_q <= '0;
              if (sync) begin
                state_q <= HELD;
`ifdef AUTO_REPEAT_EN
                rpt_q   <= '0;
`endif
              end else begin
                state_q <= IDLE;
                level_q <= 1'b0;
              end
            end else begin
              cnt_q <= cnt_q + CNT_ONE;
            end
          end
          HELD: begin
            if (!sync) begin
              state_q <= IDLE;
              level_q <= 1'b0;
            end
`ifdef AUTO_REPEAT_EN
            else if (rpt_q == RPT_LAST) begin
              press_q <= 1'b1;
              rpt_q   <= '0;
            end else begin
              rpt_q <= rpt_q + 8'd1;
            end
`endif
          end
          default: begin
            state_q <= IDLE;
            level_q <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner: cycle-level reference model plus directed scenarios.
module tb_button_conditioner;
  localparam int N_CH        = 2;
  localparam int CR          = 4;
  localparam int SYNC_STAGES = 2;
  localparam int RPT_CYC     = 8;
  localparam int LOCK_EDGES  = (1 << CR) - 1;
`ifdef AUTO_REPEAT_EN
  localparam int HOLD_PULSES = 6;
`else
  localparam int HOLD_PULSES = 1;
`endif

  logic            clk_i  = 1'b0;
  logic            rst_ni = 1'b1;
  logic            en_i   = 1'b0;
  logic [N_CH-1:0] btn_i  = '0;
  logic [N_CH-1:0] press_o;
  logic [N_CH-1:0] level_o;
  logic            valid_o;

  int checks = 0;
  int errors = 0;

  button_conditioner #(
    .N_CH(N_CH), .CR(CR), .SYNC_STAGES(SYNC_STAGES), .RPT_CYC(RPT_CYC)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en_i), .btn_i(btn_i),
    .press_o(press_o), .level_o(level_o), .valid_o(valid_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: delayed input history, hold-off countdown in enabled edges, held flag and repeat age.
  logic [N_CH-1:0] exp_press = '0;
  logic [N_CH-1:0] exp_level = '0;
  logic            exp_valid = 1'b0;
  int lock_left [N_CH];
  bit held      [N_CH];
  int age       [N_CH];
  bit hist      [N_CH][SYNC_STAGES];

  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_press = '0;
      exp_level = '0;
      exp_valid = 1'b0;
      for (int c = 0; c < N_CH; c++) begin
        lock_left[c] = 0;
        held[c]      = 1'b0;
        age[c]       = 0;
        for (int k = 0; k < SYNC_STAGES; k++) hist[c][k] = 1'b0;
      end
    end else begin
      exp_valid = en_i;
      for (int c = 0; c < N_CH; c++) begin
        bit s;
        s = hist[c][SYNC_STAGES-1];
        for (int k = SYNC_STAGES-1; k > 0; k--) hist[c][k] = hist[c][k-1];
        hist[c][0]   = btn_i[c];
        exp_press[c] = 1'b0;
        if (en_i) begin
          if (lock_left[c] > 0) begin
            lock_left[c]--;
            if (lock_left[c] == 0) begin
              held[c] = s;
              age[c]  = 0;
            end
          end else if (held[c]) begin
            if (!s) held[c] = 1'b0;
`ifdef AUTO_REPEAT_EN
            else begin
              age[c]++;
              if (age[c] == RPT_CYC) begin
                exp_press[c] = 1'b1;
                age[c]       = 0;
              end
            end
`endif
          end else if (s) begin
            exp_press[c] = 1'b1;
            lock_left[c] = LOCK_EDGES;
          end
        end
        exp_level[c] = (lock_left[c] > 0) || held[c];
      end
    end
  end

  // Per-cycle comparison and press bookkeeping.
  int cyc = 0;
  int pq0[$];
  int npress1 = 0;

  always @(posedge clk_i) begin
    cyc++;
    #1;
    check("press_o", press_o, exp_press);
    check("level_o", level_o, exp_level);
    check("valid_o", valid_o, exp_valid);
    if (press_o[0] === 1'b1) pq0.push_back(cyc);
    if (press_o[1] === 1'b1) npress1++;
  end

  task automatic ticks(input int n);
    repeat (n) @(negedge clk_i);
  endtask

  int base0;
  int base1;

  initial begin
    #1 rst_ni = 1'b0;
    #2;
    check("reset_press", press_o, 0);
    check("reset_level", level_o, 0);
    check("reset_valid", valid_o, 0);
    ticks(2);
    rst_ni = 1'b1;
    en_i   = 1'b1;
    ticks(3);

    // Clean press, then held for 60 sampled edges.
    base0 = pq0.size();
    base1 = npress1;
    btn_i[0] = 1'b1;
    for (int e = 0; e < 4; e++) begin
      @(posedge clk_i);
      #1;
      check("clean_press_edge", press_o[0], (e == 2));
      check("clean_level_edge", level_o[0], (e >= 2));
    end
    ticks(57);
    btn_i[0] = 1'b0;
    ticks(25);
    check("hold60_pulse_count", pq0.size() - base0, HOLD_PULSES);

    // Bounce: toggles every 3 cycles for 12 cycles, then stable high briefly.
    base0 = pq0.size();
    for (int i = 0; i < 4; i++) begin
      btn_i[0] = (i % 2 == 0);
      ticks(3);
    end
    btn_i[0] = 1'b1;
    ticks(8);
    btn_i[0] = 1'b0;
    ticks(25);
    check("bounce_single_pulse", pq0.size() - base0, 1);

    // Release and re-press every 5 cycles.
    base0 = pq0.size();
    for (int i = 0; i < 6; i++) begin
      btn_i[0] = 1'b1;
      ticks(5);
      btn_i[0] = 1'b0;
      ticks(5);
    end
    ticks(25);
    check("repress_pulse_count", pq0.size() - base0, 3);
    for (int i = base0 + 1; i < pq0.size(); i++)
      check("repress_gap_ge16", (pq0[i] - pq0[i-1]) >= 16, 1);
    check("ch1_quiet", npress1 - base1, 0);

    // Simultaneous press on both channels.
    btn_i = 2'b11;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk_i);
      #1;
      check("simul_press", press_o, (e == 2) ? 2'b11 : 2'b00);
    end
    ticks(10);
    btn_i = 2'b00;
    ticks(25);

    // Disable while channel 1 is pressed, then re-enable.
    en_i     = 1'b0;
    btn_i[1] = 1'b1;
    ticks(6);
    @(posedge clk_i);
    #1;
    check("disabled_press", press_o, 0);
    check("disabled_valid", valid_o, 0);
    check("disabled_level1", level_o[1], 0);
    @(negedge clk_i);
    en_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("reenable_press", press_o, 2'b10);
    check("reenable_valid", valid_o, 1);
    ticks(3);
    en_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("frozen_level1", level_o[1], 1);
    check("frozen_press", press_o, 0);
    ticks(4);
    en_i = 1'b1;
    ticks(20);
    btn_i[1] = 1'b0;
    ticks(40);

    // Reset pulsed mid-hold-off with the button still held.
    btn_i[0] = 1'b1;
    repeat (6) @(posedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    check("async_reset_press", press_o, 0);
    check("async_reset_level", level_o, 0);
    check("async_reset_valid", valid_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int e = 0; e < 3; e++) begin
      @(posedge clk_i);
      #1;
      check("post_reset_press", press_o[0], (e == 2));
    end
    ticks(5);
    btn_i[0] = 1'b0;
    ticks(25);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 The block SHALL have parameter N_CH, default 2, meaning the number of independent button channels (1..8).
REQ-002 The block SHALL have parameter CR, default 4, meaning the hold-off counter width; hold-off lasts 2^CR cycles.
REQ-003 The block SHALL have parameter SYNC_STAGES, default 2, meaning the synchroniser flop count (2..3).
REQ-004 The block SHALL have parameter RPT_CYC, default 8, meaning the auto-repeat period in enabled cycles (2..255).
REQ-005 The block SHALL have port clk_i, input, width 1: the single clock; all flops are on its rising edge.
REQ-006 The block SHALL have port rst_ni, input, width 1: asynchronous, active-low reset.
REQ-007 The block SHALL have port en_i, input, width 1: input-sampling enable.
REQ-008 The block SHALL have port btn_i, input, width N_CH: raw asynchronous button levels, active-high.
REQ-009 The block SHALL have port press_o, output, width N_CH: one-cycle press pulse per channel.
REQ-010 The block SHALL have port level_o, output, width N_CH: conditioned level, 1 in LOCK or HELD.
REQ-011 The block SHALL have port valid_o, output, width 1: en_i registered one cycle.

Function
REQ-012 Each channel SHALL pass btn_i through SYNC_STAGES flops that run regardless of en_i; "sync" below means the last stage.
REQ-013 Each channel SHALL implement the FSM states IDLE, LOCK and HELD, plus a CR-bit counter cnt; all channels are independent.
REQ-014 IDLE: on an enabled edge with sync=1 the channel SHALL register press_o=1, go to LOCK and set cnt=1.
REQ-015 LOCK: each enabled edge SHALL increment cnt; on the enabled edge with cnt=2^CR-1 the channel SHALL set cnt=0 and go to HELD if sync=1, else to IDLE.
REQ-016 Transitions out of LOCK SHALL ignore sync bounces while in LOCK (bounce suppression).
REQ-017 HELD: on an enabled edge with sync=0 the channel SHALL go to IDLE.
REQ-018 press_o SHALL be high for exactly one cycle per press event; consecutive press pulses on one channel SHALL be at least 2^CR cycles apart.
REQ-019 Latency SHALL be SYNC_STAGES+1 edges from a btn_i rise (set up before an edge) to press_o=1, in IDLE with en_i=1.
REQ-020 With en_i=0, the FSM and counters SHALL freeze, press_o SHALL be all 0, and valid_o SHALL be 0 on the next edge; level_o SHALL keep its state.
REQ-021 A button already held when en_i rises SHALL produce press_o on the first enabled edge (level-sensitive in IDLE).
REQ-022 Simultaneous presses on several channels SHALL produce simultaneous pulses; there is no arbitration.

Reset
REQ-023 rst_ni=0 SHALL immediately force all FSMs to IDLE, cnt and the repeat counters to 0, synchroniser flops to 0, and press_o, level_o and valid_o to 0.
REQ-024 Reset asserted mid-LOCK or mid-HELD SHALL discard the pending state; a button still held after reset release SHALL give a fresh press after SYNC_STAGES+1 edges.

Configuration
REQ-025 Macro AUTO_REPEAT_EN defined: HELD SHALL run an 8-bit repeat counter rpt, cleared on HELD entry and incremented per enabled edge; at rpt=RPT_CYC-1 it SHALL pulse press_o and clear rpt.
REQ-026 Under AUTO_REPEAT_EN, a release and a repeat on the same edge SHALL resolve as release: no pulse, go to IDLE.
REQ-027 Macro AUTO_REPEAT_EN undefined: rpt logic SHALL be absent and HELD SHALL produce no pulses.

Verification (N_CH=2, CR=4, SYNC_STAGES=2, RPT_CYC=8)
REQ-028 Clean press: btn_i[0] rises before edge 0 with en_i=1 -> press_o[0]=1 only after edge 2, level_o[0]=1 from edge 2.
REQ-029 Bounce: btn_i[0] toggles every 3 cycles for 12 cycles, then is stable at 1 -> exactly one press_o[0] pulse.
REQ-030 Release and repress at 5-cycle spacing -> press pulses no closer than 16 cycles.
REQ-031 Disable: en_i=0 while btn_i[1] is pressed -> press_o=0, valid_o=0; en_i=1 -> press_o[1] on the first enabled edge.
REQ-032 AUTO_REPEAT_EN, held for 60 cycles -> one initial pulse, then pulses every 8 cycles after HELD entry; none without the macro.
REQ-033 rst_ni pulsed low mid-LOCK -> all outputs 0 asynchronously; held button re-pulses 3 edges after release.
